// File: rtl/dcpu16_arb.sv
// ---------------------------------------------------------------------------
// dcpu16_arb
//
// Two-master, one-slave bus arbiter for a DCPU-16 style core. The CPU has a
// fetch bus (f_*) and a general bus (g_*); both compete for one memory port
// (m_*). Only one access is in flight at a time.
//
// Access sequence:
//   IDLE -> FBUS/GBUS (grant: memory address/data/write-enable registered)
//        -> DONE      (memory acknowledged or wait counter expired)
//        -> IDLE      (the requester's ack pulses while in DONE)
//
// Ties are broken round robin. The last-grant flag resets to G, so F wins
// the first tie after reset. An access that waits TMO cycles without m_ack
// is completed with read data 16'h0000 and a one-cycle err pulse alongside
// the ack.
//
// Parameters:
//   TMO    cycles a granted access waits for m_ack before it is aborted
//          (2..255)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   f_adr/f_stb/f_wre/f_dto       fetch-bus request from CPU
//   f_dti/f_ack                   fetch-bus read data and ack pulse
//   g_adr/g_stb/g_wre/g_dto       general-bus request from CPU
//   g_dti/g_ack                   general-bus read data and ack pulse
//   m_adr/m_stb/m_wre/m_dto       memory request
//   m_dti/m_ack                   memory read data and acknowledge
//   err                           one-cycle pulse: access ended by timeout
// ---------------------------------------------------------------------------
module dcpu16_arb #(
    parameter int unsigned TMO = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [15:0] f_adr,
    input  logic        f_stb,
    input  logic        f_wre,
    input  logic [15:0] f_dto,
    output logic [15:0] f_dti,
    output logic        f_ack,

    input  logic [15:0] g_adr,
    input  logic        g_stb,
    input  logic        g_wre,
    input  logic [15:0] g_dto,
    output logic [15:0] g_dti,
    output logic        g_ack,

    output logic [15:0] m_adr,
    output logic        m_stb,
    output logic        m_wre,
    output logic [15:0] m_dto,
    input  logic [15:0] m_dti,
    input  logic        m_ack,

    output logic        err
);

    localparam int         NBUS      = 2;
    localparam logic       BUS_F     = 1'b0;
    localparam logic       BUS_G     = 1'b1;
    // Wait-counter value on the last cycle an access may still be acked.
    localparam logic [7:0] WAIT_LAST = 8'(TMO - 1);

    typedef enum logic [1:0] {
        IDLE,
        FBUS,
        GBUS,
        DONE
    } state_t;

    // -----------------------------------------------------------------------
    // Requesting buses gathered into arrays, index 0 = F, index 1 = G
    // -----------------------------------------------------------------------
    logic [15:0] bus_adr [NBUS];
    logic [15:0] bus_dto [NBUS];
    logic        bus_wre [NBUS];
    logic        bus_stb [NBUS];

    assign bus_adr[0] = f_adr;
    assign bus_dto[0] = f_dto;
    assign bus_wre[0] = f_wre;
    assign bus_stb[0] = f_stb;
    assign bus_adr[1] = g_adr;
    assign bus_dto[1] = g_dto;
    assign bus_wre[1] = g_wre;
    assign bus_stb[1] = g_stb;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t      state_reg, state_next;
    // Bus granted most recently. It updates on every grant, so throughout
    // FBUS/GBUS/DONE it also names the bus currently being served.
    logic        last_reg, last_next;
    logic [7:0]  wait_reg, wait_next;
    logic [15:0] m_adr_reg, m_adr_next;
    logic [15:0] m_dto_reg, m_dto_next;
    logic        m_wre_reg, m_wre_next;
    logic        err_reg, err_next;

    logic [15:0] dti_reg [NBUS];
    logic        ack_reg [NBUS];

    logic        grant_valid;
    logic        grant_bus;
    logic        in_access;
    logic        timeout_hit;
    logic        finish;

    // -----------------------------------------------------------------------
    // Round-robin grant decision (only acted on in IDLE)
    // -----------------------------------------------------------------------
    always_comb begin
        grant_valid = bus_stb[0] | bus_stb[1];
        if (bus_stb[0] && bus_stb[1]) begin
            grant_bus = ~last_reg;
        end else begin
            grant_bus = bus_stb[1] ? BUS_G : BUS_F;
        end
    end

    assign in_access   = (state_reg == FBUS) || (state_reg == GBUS);
    // An ack on the final wait cycle wins over the timeout.
    assign timeout_hit = in_access && !m_ack && (wait_reg == WAIT_LAST);
    assign finish      = in_access && (m_ack || (wait_reg == WAIT_LAST));

    // -----------------------------------------------------------------------
    // Next-state / datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        wait_next  = wait_reg;
        m_adr_next = m_adr_reg;
        m_dto_next = m_dto_reg;
        m_wre_next = m_wre_reg;
        err_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                // m_ack is ignored here; only requests matter.
                if (grant_valid) begin
                    state_next = (grant_bus == BUS_G) ? GBUS : FBUS;
                    last_next  = grant_bus;
                    wait_next  = 8'd0;
                    m_adr_next = bus_adr[grant_bus];
                    m_dto_next = bus_dto[grant_bus];
                    m_wre_next = bus_wre[grant_bus];
                end
            end

            FBUS, GBUS: begin
                if (finish) begin
                    state_next = DONE;
                    err_next   = timeout_hit;
                end else begin
                    wait_next = wait_reg + 8'd1;
                end
            end

            DONE: begin
                // Requests are not sampled here, so a CPU that drops its
                // strobe on the ack edge is never granted again.
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            last_reg  <= BUS_G;
            wait_reg  <= 8'd0;
            m_adr_reg <= 16'h0000;
            m_dto_reg <= 16'h0000;
            m_wre_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            wait_reg  <= wait_next;
            m_adr_reg <= m_adr_next;
            m_dto_reg <= m_dto_next;
            m_wre_reg <= m_wre_next;
            err_reg   <= err_next;
        end
    end

    // -----------------------------------------------------------------------
    // Per-bus return path: read-data register and ack pulse. The ack is set
    // on the edge that enters DONE, so it is high exactly while in DONE.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NBUS; gi++) begin : g_bus
            logic served;
            assign served = finish && (last_reg == 1'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    dti_reg[gi] <= 16'h0000;
                    ack_reg[gi] <= 1'b0;
                end else begin
                    ack_reg[gi] <= served;
                    if (served) begin
                        dti_reg[gi] <= m_ack ? m_dti : 16'h0000;
                    end
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign m_stb = in_access;
    assign m_adr = m_adr_reg;
    assign m_dto = m_dto_reg;
    assign m_wre = m_wre_reg;
    assign err   = err_reg;
    assign f_dti = dti_reg[0];
    assign f_ack = ack_reg[0];
    assign g_dti = dti_reg[1];
    assign g_ack = ack_reg[1];

endmodule

// File: tb/tb_dcpu16_arb.sv
// ---------------------------------------------------------------------------
// tb_dcpu16_arb
//
// Bench for dcpu16_arb. Two behavioural CPUs drive the f/g buses and a
// behavioural memory answers m_stb after a chosen number of wait cycles.
// The reference model is a per-access timeline: once a grant is predicted
// from the round-robin rule, the access must show m_stb for
// min(wait+1, TMO) cycles, then one ack cycle (with err when the memory was
// too slow), then one idle cycle before the next request is taken.
// Directed scenarios run first, then a randomized phase with stray acks
// and occasional resets.
// ---------------------------------------------------------------------------
module tb_dcpu16_arb;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] f_adr, f_dto, f_dti;
    logic        f_stb, f_wre, f_ack;
    logic [15:0] g_adr, g_dto, g_dti;
    logic        g_stb, g_wre, g_ack;
    logic [15:0] m_adr, m_dto, m_dti;
    logic        m_stb, m_wre, m_ack;
    logic        err;

    dcpu16_arb #(.TMO(TMO)) dut (
        .clk   (clk),
        .rst   (rst),
        .f_adr (f_adr),
        .f_stb (f_stb),
        .f_wre (f_wre),
        .f_dto (f_dto),
        .f_dti (f_dti),
        .f_ack (f_ack),
        .g_adr (g_adr),
        .g_stb (g_stb),
        .g_wre (g_wre),
        .g_dto (g_dto),
        .g_dti (g_dti),
        .g_ack (g_ack),
        .m_adr (m_adr),
        .m_stb (m_stb),
        .m_wre (m_wre),
        .m_dto (m_dto),
        .m_dti (m_dti),
        .m_ack (m_ack),
        .err   (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- bench memory and CPU intent ----------------
    logic [15:0] mem [256];
    logic        req_on  [2];
    logic [15:0] req_adr [2];
    logic [15:0] req_dto [2];
    logic        req_wre [2];
    int          gap     [2];

    // values driven at the last negedge (what the DUT sampled)
    logic        drove_stb [2];
    logic [15:0] drove_adr [2];
    logic [15:0] drove_dto [2];
    logic        drove_wre [2];
    logic        drove_rst;

    logic        obs_ack [2];

    bit auto_req    = 0;
    bit stray_force = 0;
    bit rst_req     = 0;
    int force_w     = -1;

    // ---------------- reference model ----------------
    bit          busy = 0;
    int          t_in, cur_len, cur_w, own;
    int          last_own = 1;
    logic [15:0] cur_adr, cur_dto, cur_data;
    logic        cur_wre;
    bit          cur_tmo;
    logic [15:0] exp_dti [2];
    bit          dti_known [2];

    task automatic set_req(input int b, input logic [15:0] adr, input logic wre, input logic [15:0] dto);
        req_on[b]  = 1'b1;
        req_adr[b] = adr;
        req_wre[b] = wre;
        req_dto[b] = dto;
    endtask

    // One clock: observe and check at the negedge, then drive the next inputs.
    task automatic cycle();
        logic [15:0] dti_obs [2];
        @(negedge clk);
        obs_ack[0] = f_ack;
        obs_ack[1] = g_ack;
        dti_obs[0] = f_dti;
        dti_obs[1] = g_dti;

        if (drove_rst) begin
            check_val("rst_m_stb", m_stb, 0);
            check_val("rst_m_wre", m_wre, 0);
            check_val("rst_m_adr", m_adr, 0);
            check_val("rst_m_dto", m_dto, 0);
            check_val("rst_f_ack", f_ack, 0);
            check_val("rst_g_ack", g_ack, 0);
            check_val("rst_err", err, 0);
            busy     = 0;
            last_own = 1;
            for (int b = 0; b < 2; b++) begin
                exp_dti[b]   = 16'h0000;
                dti_known[b] = 1;
            end
        end else begin
            if (!busy && (drove_stb[0] || drove_stb[1])) begin
                if (drove_stb[0] && drove_stb[1]) own = 1 - last_own;
                else own = drove_stb[1] ? 1 : 0;
                last_own = own;
                cur_adr  = drove_adr[own];
                cur_dto  = drove_dto[own];
                cur_wre  = drove_wre[own];
                cur_data = mem[cur_adr[7:0]];
                if (force_w >= 0) cur_w = force_w;
                else if ($urandom_range(0, 9) < 6) cur_w = $urandom_range(0, 3);
                else cur_w = TMO - 3 + $urandom_range(0, 4);
                cur_tmo = (cur_w + 1 > TMO);
                cur_len = cur_tmo ? TMO : cur_w + 1;
                busy    = 1;
                t_in    = 0;
            end
            if (busy) begin
                t_in++;
                if (t_in <= cur_len) begin
                    check_val("acc_m_stb", m_stb, 1);
                    check_val("acc_m_adr", m_adr, cur_adr);
                    check_val("acc_m_wre", m_wre, cur_wre);
                    check_val("acc_m_dto", m_dto, cur_dto);
                    check_val("acc_f_ack", f_ack, 0);
                    check_val("acc_g_ack", g_ack, 0);
                    check_val("acc_err", err, 0);
                end else if (t_in == cur_len + 1) begin
                    check_val("done_m_stb", m_stb, 0);
                    check_val("done_own_ack", obs_ack[own], 1);
                    check_val("done_other_ack", obs_ack[1 - own], 0);
                    check_val("done_err", err, cur_tmo);
                    if (cur_tmo) begin
                        exp_dti[own]   = 16'h0000;
                        dti_known[own] = 1;
                    end else if (!cur_wre) begin
                        exp_dti[own]   = cur_data;
                        dti_known[own] = 1;
                    end else begin
                        dti_known[own] = 0;
                    end
                end else begin
                    check_val("post_m_stb", m_stb, 0);
                    check_val("post_f_ack", f_ack, 0);
                    check_val("post_g_ack", g_ack, 0);
                    check_val("post_err", err, 0);
                    busy = 0;
                end
            end else begin
                check_val("idle_m_stb", m_stb, 0);
                check_val("idle_f_ack", f_ack, 0);
                check_val("idle_g_ack", g_ack, 0);
                check_val("idle_err", err, 0);
            end
        end
        for (int b = 0; b < 2; b++) begin
            if (dti_known[b]) check_val((b == 0) ? "f_dti" : "g_dti", dti_obs[b], exp_dti[b]);
        end

        // ---- memory response ----
        if (busy && t_in <= cur_len) begin
            if (t_in == cur_w + 1) begin
                m_ack = 1'b1;
                if (cur_wre) begin
                    m_dti = 16'($urandom);
                    mem[cur_adr[7:0]] = cur_dto;
                end else begin
                    m_dti = mem[cur_adr[7:0]];
                end
            end else begin
                m_ack = 1'b0;
                m_dti = 16'($urandom);
            end
        end else begin
            m_ack = stray_force || (auto_req && $urandom_range(0, 7) == 0);
            m_dti = 16'($urandom);
        end

        // ---- CPUs ----
        for (int b = 0; b < 2; b++) begin
            if (req_on[b] && obs_ack[b]) begin
                req_on[b] = 1'b0;
                gap[b]    = $urandom_range(0, 3);
            end else if (!req_on[b] && auto_req) begin
                if (gap[b] > 0) gap[b]--;
                else if ($urandom_range(0, 2) == 0)
                    set_req(b, 16'($urandom), ($urandom_range(0, 2) == 0), 16'($urandom));
            end
            drove_stb[b] = req_on[b];
            drove_adr[b] = req_on[b] ? req_adr[b] : 16'($urandom);
            drove_wre[b] = req_on[b] ? req_wre[b] : 1'($urandom);
            drove_dto[b] = req_on[b] ? req_dto[b] : 16'($urandom);
        end
        f_stb = drove_stb[0]; f_adr = drove_adr[0]; f_wre = drove_wre[0]; f_dto = drove_dto[0];
        g_stb = drove_stb[1]; g_adr = drove_adr[1]; g_wre = drove_wre[1]; g_dto = drove_dto[1];

        drove_rst = rst_req || (auto_req && $urandom_range(0, 99) == 0);
        rst       = drove_rst;
        rst_req   = 0;
    endtask

    // One complete directed access; returns cycles until ack, m_stb cycles,
    // and the err / read data seen together with the ack.
    task automatic access(input int b, input logic [15:0] adr, input logic wre,
                          input logic [15:0] dto, input int w,
                          output int n, output int stbs, output logic err_seen,
                          output logic [15:0] dti_seen);
        force_w = w;
        set_req(b, adr, wre, dto);
        cycle();
        n    = 0;
        stbs = 0;
        do begin
            cycle();
            n++;
            if (m_stb) stbs++;
        end while (!obs_ack[b] && n < 400);
        check_val("access_bound", obs_ack[b], 1);
        err_seen = err;
        dti_seen = (b == 0) ? f_dti : g_dti;
        cycle();
    endtask

    task automatic tie_round(input int first, input string tag);
        int order[$];
        int n;
        force_w = 1;
        set_req(0, 16'h0100, 1'b0, 16'h0000);
        set_req(1, 16'h0200, 1'b0, 16'h0000);
        n = 0;
        while (order.size() < 2 && n < 200) begin
            cycle();
            n++;
            for (int b = 0; b < 2; b++) if (obs_ack[b]) order.push_back(b);
        end
        check_val({tag, "_count"}, order.size(), 2);
        if (order.size() == 2) begin
            check_val({tag, "_first"}, order[0], first);
            check_val({tag, "_second"}, order[1], 1 - first);
        end
        cycle();
    endtask

    initial begin
        int          n, stbs;
        logic        e;
        logic [15:0] d;

        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 257) ^ 16'h5A5A;
        for (int b = 0; b < 2; b++) begin
            req_on[b] = 0; req_adr[b] = 0; req_dto[b] = 0; req_wre[b] = 0; gap[b] = 0;
            drove_stb[b] = 0; drove_adr[b] = 0; drove_dto[b] = 0; drove_wre[b] = 0;
            exp_dti[b] = 0; dti_known[b] = 0; obs_ack[b] = 0;
        end
        f_stb = 0; f_adr = 0; f_wre = 0; f_dto = 0;
        g_stb = 0; g_adr = 0; g_wre = 0; g_dto = 0;
        m_ack = 0; m_dti = 0;
        rst = 1; drove_rst = 1;

        cycle();
        cycle();

        // Single read, zero-wait memory
        mem[8'h10] = 16'hBEEF;
        access(0, 16'h0010, 1'b0, 16'h0000, 0, n, stbs, e, d);
        check_val("read_latency", n, 2);
        check_val("read_data", d, 16'hBEEF);
        check_val("read_err", e, 0);

        // Tie handling: F first after reset, alternation afterwards
        rst_req = 1;
        cycle();
        cycle();
        tie_round(0, "tie1");
        tie_round(0, "tie2");
        access(0, 16'h0003, 1'b0, 16'h0000, 0, n, stbs, e, d);
        tie_round(1, "tie3");

        // Write with three wait cycles
        access(1, 16'h8000, 1'b1, 16'h1234, 3, n, stbs, e, d);
        check_val("write_latency", n, 5);
        check_val("write_stb_cycles", stbs, 4);
        check_val("write_err", e, 0);

        // Timeout: memory never answers
        access(0, 16'h0020, 1'b0, 16'h0000, 200, n, stbs, e, d);
        check_val("tmo_stb_cycles", stbs, TMO);
        check_val("tmo_err", e, 1);
        check_val("tmo_data", d, 16'h0000);

        // Ack on the last allowed cycle completes normally
        mem[8'h21] = 16'hA5C3;
        access(0, 16'h0021, 1'b0, 16'h0000, TMO - 1, n, stbs, e, d);
        check_val("edge_stb_cycles", stbs, TMO);
        check_val("edge_err", e, 0);
        check_val("edge_data", d, 16'hA5C3);

        // Reset while the general bus is being served
        force_w = 200;
        set_req(1, 16'h0040, 1'b0, 16'h0000);
        cycle();
        repeat (5) cycle();
        req_on[1] = 0;
        rst_req   = 1;
        cycle();
        cycle();
        check_val("rst_mid_g_ack", obs_ack[1], 0);
        access(0, 16'h0010, 1'b0, 16'h0000, 0, n, stbs, e, d);
        check_val("after_rst_latency", n, 2);
        check_val("after_rst_data", d, 16'hBEEF);

        // Stray memory acks while idle
        stray_force = 1;
        repeat (4) begin
            cycle();
            check_val("stray_m_stb", m_stb, 0);
            check_val("stray_ack", {f_ack, g_ack}, 0);
        end
        stray_force = 0;
        access(1, 16'h0005, 1'b0, 16'h0000, 0, n, stbs, e, d);
        check_val("post_stray_latency", n, 2);

        // Randomized traffic with stray acks and occasional resets
        force_w  = -1;
        auto_req = 1;
        repeat (4000) cycle();
        auto_req = 0;
        repeat (100) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dcpu16_arb.md
DCPU16_ARB -- requirements
Module: dcpu16_arb

Interface
REQ-001 Parameter TMO, default 16, number of cycles a granted access waits for m_ack before it is aborted (legal range 2..255).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high, single clock domain.
REQ-004 f_adr  input  16  fetch-bus address from CPU.
REQ-005 f_stb  input  1  fetch-bus request strobe, held by CPU until f_ack.
REQ-006 f_wre  input  1  fetch-bus write enable (1 = write).
REQ-007 f_dto  input  16  fetch-bus write data.
REQ-008 f_dti  output  16  fetch-bus read data to CPU.
REQ-009 f_ack  output  1  fetch-bus acknowledge, one-cycle pulse.
REQ-010 g_adr, g_stb, g_wre, g_dto, g_dti, g_ack  same widths, directions and meanings as the f_* ports, for the general bus.
REQ-011 m_adr  output  16  memory address.
REQ-012 m_stb  output  1  memory request strobe.
REQ-013 m_wre  output  1  memory write enable.
REQ-014 m_dto  output  16  memory write data.
REQ-015 m_dti  input  16  memory read data, valid when m_ack = 1.
REQ-016 m_ack  input  1  memory acknowledge.
REQ-017 err  output  1  one-cycle pulse marking an access completed by timeout.

Function
REQ-018 The arbiter SHALL implement the states IDLE, FBUS, GBUS and DONE.
REQ-019 IDLE: if exactly one of f_stb or g_stb is high, the arbiter SHALL go to FBUS or GBUS respectively on the next edge.
REQ-020 IDLE with f_stb and g_stb both high: the arbiter SHALL grant the bus not granted last (round robin); the last-grant flag resets to G, so F wins the first tie.
REQ-021 On the grant edge, the arbiter SHALL register m_adr, m_wre and m_dto from the granted bus; they SHALL stay stable until the state leaves FBUS or GBUS.
REQ-022 m_stb SHALL be 1 exactly while the state is FBUS or GBUS.
REQ-023 In FBUS or GBUS with m_ack = 1, the arbiter SHALL capture m_dti into the granted bus's *_dti register and go to DONE.
REQ-024 In DONE, the arbiter SHALL pulse the granted bus's *_ack high for one cycle, then return to IDLE.
REQ-025 A request is sampled no earlier than the cycle after DONE, so a CPU dropping stb on its ack edge is never re-granted.
REQ-026 Latency: stb seen in IDLE at cycle n with zero-wait memory (m_ack at n+1) gives *_ack at n+2.
REQ-027 The non-granted bus's *_ack SHALL remain 0; its *_dti SHALL hold its last value.
REQ-028 Write accesses SHALL follow the same sequence; the captured *_dti value on writes is don't-care.
REQ-029 An 8-bit wait counter SHALL clear on grant and increment each cycle in FBUS or GBUS without m_ack.
REQ-030 When the wait counter reaches TMO-1 without m_ack: next state DONE, m_stb drops, *_dti loads 16'h0000, and err pulses together with *_ack.
REQ-031 m_ack arriving on the same cycle the timeout is reached SHALL count as a normal completion (data captured, no err).
REQ-032 m_ack received in IDLE or DONE SHALL be ignored.
REQ-033 The last-grant flag SHALL update on every grant.

Reset
REQ-034 While rst = 1 at an edge:
- state goes to IDLE and the last-grant flag to G;
- m_stb, m_wre, f_ack, g_ack and err go to 0;
- m_adr, m_dto, f_dti, g_dti and the wait counter go to 16'h0000 / 0.
REQ-035 Reset during FBUS, GBUS or DONE SHALL abort the access with no ack and no err; the first request after reset release is sampled in IDLE as usual.

Verification
REQ-036 The bench SHALL cover these scenarios:
- Single read: f_stb=1, f_adr=16'h0010, memory returns 16'hBEEF one cycle after m_stb -> m_adr=16'h0010, m_wre=0, f_ack one pulse with f_dti=16'hBEEF at cycle n+2, g_ack=0.
- Tie: f_stb and g_stb rise together after reset, both held until acked -> F served first, then G; the next tie goes to F again only after G was served (alternating grants).
- Write: g_stb=1, g_wre=1, g_adr=16'h8000, g_dto=16'h1234, m_ack after 3 wait cycles -> m_wre=1, m_dto=16'h1234 stable throughout, single g_ack pulse.
- Timeout: TMO=16, m_ack held 0 -> m_stb high exactly 16 cycles, then f_ack, err, f_dti=16'h0000 in the same cycle; m_ack arriving on cycle 16 completes normally with err=0.
- Reset mid-access: rst asserted in GBUS -> next edge all outputs at reset values, no g_ack; a later f_stb is served normally.
- Stray ack: m_ack pulsed while IDLE -> no state change and no ack outputs.
